dlx_ctrl_pipe: RTL and testbench
================================

DLX_CTRL_PIPE -- requirements
Module: dlx_ctrl_pipe

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- MULT_LAT, 4: FP multiply occupancy in cycles, legal 2..15.
- CTRL_DEPTH, 3: registered control stages (EX, MEM, WB), legal 2..3.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- if_valid, in, 1: if_instr holds a valid fetched instruction.
- if_instr, in, [0:31]: instruction; bit 0 is MSB, opcode [0:5], func [26:31].
- id_ready, out, 1: decode accepts if_instr this cycle.
- ex_taken, in, 1: EX resolved a taken branch or jump this cycle.
- ex_ctrl, out, CTRL_W: control bundle, EX stage.
- mem_ctrl, out, CTRL_W: control bundle, MEM stage.
- wb_ctrl, out, CTRL_W: control bundle, WB stage; tied to all-zero when CTRL_DEPTH=2.
- stall_cnt, out, 16: saturating count of stall cycles.

Function
REQ-003 Bundle fields: valid, reg_dst, reg_wr, fp_wr, fp_rd, ext_op, alu_src, mem_wr, mem2reg, branch, branch_ne, jump, alu_ctr[4], rd[5], rs1[5], rs2[5].
REQ-004 Decode: alu_src = opcode[0]|[1]|[2]; mem_wr for 101xxx; mem2reg for 100xxx; reg_dst for 00000x.
REQ-005 Branch on 0001xx: branch set when bit 5=0, branch_ne when bit 5=1. Jump on 01001x.
REQ-006 reg_wr is 0 for stores, branches, jumps and the nop 32'h00000013; otherwise 1.
REQ-007 alu_ctr:
- R-type (000000): func map add/addu 0101, sub/subu 1101, and 0000, or 0001, xor 0010, seq 1000, sne 1001, slt 1110, sgt 1100, sle 1011, sge 1010, sll 0100, srl 0111, sra 0110.
- 000001: 0011.
- Loads/stores: 0101.
- I-type: same ops keyed by opcode 001000..011101.
- Unlisted codes: 0101.
REQ-008 ext_op is 0 for opcodes 001001 and 001011 and for instruction 32'h04000016; otherwise 1. fp_rd is set when func=110100; fp_wr is set when func=110101.
REQ-009 rd is [16:20] when reg_dst=1, else [11:15]. rs1 is [6:10]; rs2 is [11:15].
REQ-010 Latency: an instruction accepted in cycle N appears on ex_ctrl in N+1, mem_ctrl in N+2, and wb_ctrl in N+3.
REQ-011 Load-use: when ex_ctrl.valid & mem2reg and ex_ctrl.rd is nonzero and equals the decoding rs1 (or rs2, for R-type or store), id_ready=0 and a bubble (all-zero bundle) enters EX for exactly 1 cycle.
REQ-012 Flush: ex_taken=1 forces the next ex_ctrl to a bubble and drops if_instr; flush overrides load-use and mult stalls in the same cycle.
REQ-013 if_valid=0 injects a bubble; id_ready stays 1 unless stalled.
REQ-014 stall_cnt increments each cycle id_ready=0 and saturates at 16'hFFFF.

Reset
REQ-015 While rst=1 at a clk edge:
- all bundles clear to zero;
- stall_cnt clears to 0;
- the mult counter clears to 0;
- id_ready is 1 in the cycle after reset.
REQ-016 Reset asserted mid-stall abandons the stall; nothing is replayed.

Configuration
REQ-017 Macro DLX_FP_MULT_INTERLOCK_EN, when defined:
- decoding an 000001 instruction loads an idle counter to MULT_LAT-1;
- while the counter is nonzero, any further 000001 or fp_rd instruction holds id_ready=0, and the counter decrements each cycle.
REQ-018 Without the macro, the counter and logic are absent and 000001 instructions issue back-to-back with no stall.

Structure
REQ-019 Package dlx_ctrl_pkg holds the bundle typedef, CTRL_W, opcode/func constants, the alu_ctr encodings and NOP_INSTR.
REQ-020 Sub-module dlx_ctrl_dec holds the pure combinational decode (REQ-004..009); dlx_ctrl_pipe instantiates it and owns all state.

Verification
REQ-021 Directed scenarios:
- add r3,r1,r2 (32'h00221820) -> ex_ctrl reg_wr=1, reg_dst=1, alu_ctr=0101, rd=3 after 1 cycle; wb_ctrl the same after 3 cycles.
- lw r5,0(r1) then add r6,r5,r2 -> id_ready=0 for 1 cycle, one bubble in EX, stall_cnt=1.
- beqz then ex_taken=1 -> next ex_ctrl.valid=0; the following instruction decodes normally.
- Two back-to-back 000001 ops with macro on and MULT_LAT=4 -> second stalled 3 cycles; with macro off -> 0 stall.
- nop 32'h00000013 -> reg_wr=0, valid=1.
- rst asserted during a load-use stall -> all bundles zero, stall_cnt=0, id_ready=1 the next cycle.

Source files
------------

// File: rtl/dlx_ctrl_pkg.sv
// dlx_ctrl_pkg: shared definitions for the DLX decode/control pipeline.
// Holds the per-stage control bundle, its width, the opcode/func codes the
// decoder keys on, the ALU control encodings and special instruction words.
package dlx_ctrl_pkg;

  // Control bundle carried EX -> MEM -> WB; the first member is the MSB.
  typedef struct packed {
    logic       valid;
    logic       reg_dst;
    logic       reg_wr;
    logic       fp_wr;
    logic       fp_rd;
    logic       ext_op;
    logic       alu_src;
    logic       mem_wr;
    logic       mem2reg;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic [3:0] alu_ctr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam logic [31:0] EXT_ZERO_INSTR = 32'h0400_0016;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_FPR   = 6'h01;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBI  = 6'h0a;
  localparam logic [5:0] OP_SUBUI = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_SLLI  = 6'h14;
  localparam logic [5:0] OP_SRLI  = 6'h16;
  localparam logic [5:0] OP_SRAI  = 6'h17;
  localparam logic [5:0] OP_SEQI  = 6'h18;
  localparam logic [5:0] OP_SNEI  = 6'h19;
  localparam logic [5:0] OP_SLTI  = 6'h1a;
  localparam logic [5:0] OP_SGTI  = 6'h1b;
  localparam logic [5:0] OP_SLEI  = 6'h1c;
  localparam logic [5:0] OP_SGEI  = 6'h1d;

  // R-type function codes
  localparam logic [5:0] F_SLL   = 6'h04;
  localparam logic [5:0] F_SRL   = 6'h06;
  localparam logic [5:0] F_SRA   = 6'h07;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_SEQ   = 6'h28;
  localparam logic [5:0] F_SNE   = 6'h29;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SGT   = 6'h2b;
  localparam logic [5:0] F_SLE   = 6'h2c;
  localparam logic [5:0] F_SGE   = 6'h2d;
  localparam logic [5:0] F_FP_RD = 6'h34;
  localparam logic [5:0] F_FP_WR = 6'h35;

  // ALU control encodings
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_FPR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SEQ = 4'b1000;
  localparam logic [3:0] ALU_SNE = 4'b1001;
  localparam logic [3:0] ALU_SGE = 4'b1010;
  localparam logic [3:0] ALU_SLE = 4'b1011;
  localparam logic [3:0] ALU_SGT = 4'b1100;
  localparam logic [3:0] ALU_SUB = 4'b1101;
  localparam logic [3:0] ALU_SLT = 4'b1110;

endpackage

// File: rtl/dlx_ctrl_dec.sv
// dlx_ctrl_dec: purely combinational DLX instruction decoder.
// Ports:
//   instr - 32-bit instruction, bit 0 is the MSB (opcode [0:5], func [26:31])
//   ctrl  - decoded control bundle; valid is always 1, the pipeline gates it
module dlx_ctrl_dec
  import dlx_ctrl_pkg::*;
(
  input  logic [0:31] instr,
  output ctrl_t       ctrl
);

  logic [5:0] op_s;
  logic [5:0] fn_s;
  logic [3:0] alu_s;

  // op_s[5] is the opcode MSB, op_s[0] is instruction bit 5.
  assign op_s = instr[0:5];
  assign fn_s = instr[26:31];

  // ALU control: R-type by func, immediates by opcode, everything else adds.
  always_comb begin
    alu_s = ALU_ADD;
    if (op_s == OP_RTYPE) begin
      case (fn_s)
        F_ADD, F_ADDU: alu_s = ALU_ADD;
        F_SUB, F_SUBU: alu_s = ALU_SUB;
        F_AND:         alu_s = ALU_AND;
        F_OR:          alu_s = ALU_OR;
        F_XOR:         alu_s = ALU_XOR;
        F_SEQ:         alu_s = ALU_SEQ;
        F_SNE:         alu_s = ALU_SNE;
        F_SLT:         alu_s = ALU_SLT;
        F_SGT:         alu_s = ALU_SGT;
        F_SLE:         alu_s = ALU_SLE;
        F_SGE:         alu_s = ALU_SGE;
        F_SLL:         alu_s = ALU_SLL;
        F_SRL:         alu_s = ALU_SRL;
        F_SRA:         alu_s = ALU_SRA;
        default:       alu_s = ALU_ADD;
      endcase
    end else if (op_s == OP_FPR) begin
      alu_s = ALU_FPR;
    end else begin
      case (op_s)
        OP_ADDI, OP_ADDUI: alu_s = ALU_ADD;
        OP_SUBI, OP_SUBUI: alu_s = ALU_SUB;
        OP_ANDI:           alu_s = ALU_AND;
        OP_ORI:            alu_s = ALU_OR;
        OP_XORI:           alu_s = ALU_XOR;
        OP_SEQI:           alu_s = ALU_SEQ;
        OP_SNEI:           alu_s = ALU_SNE;
        OP_SLTI:           alu_s = ALU_SLT;
        OP_SGTI:           alu_s = ALU_SGT;
        OP_SLEI:           alu_s = ALU_SLE;
        OP_SGEI:           alu_s = ALU_SGE;
        OP_SLLI:           alu_s = ALU_SLL;
        OP_SRLI:           alu_s = ALU_SRL;
        OP_SRAI:           alu_s = ALU_SRA;
        default:           alu_s = ALU_ADD;
      endcase
    end
  end

  // Remaining bundle fields from opcode class, func and register fields.
  always_comb begin
    ctrl           = '0;
    ctrl.valid     = 1'b1;
    ctrl.alu_src   = |op_s[5:3];
    ctrl.mem_wr    = (op_s[5:3] == 3'b101);
    ctrl.mem2reg   = (op_s[5:3] == 3'b100);
    ctrl.reg_dst   = (op_s[5:1] == 5'b00000);
    ctrl.branch    = (op_s[5:2] == 4'b0001) && !op_s[0];
    ctrl.branch_ne = (op_s[5:2] == 4'b0001) && op_s[0];
    ctrl.jump      = (op_s[5:1] == 5'b01001);
    ctrl.reg_wr    = !(ctrl.mem_wr || ctrl.branch || ctrl.branch_ne ||
                       ctrl.jump || (instr == NOP_INSTR));
    ctrl.ext_op    = !((op_s == OP_ADDUI) || (op_s == OP_SUBUI) ||
                       (instr == EXT_ZERO_INSTR));
    ctrl.fp_rd     = (fn_s == F_FP_RD);
    ctrl.fp_wr     = (fn_s == F_FP_WR);
    ctrl.alu_ctr   = alu_s;
    ctrl.rd        = ctrl.reg_dst ? instr[16:20] : instr[11:15];
    ctrl.rs1       = instr[6:10];
    ctrl.rs2       = instr[11:15];
  end

endmodule

// File: rtl/dlx_ctrl_pipe.sv
// dlx_ctrl_pipe: DLX decode stage plus registered EX/MEM/WB control pipeline
// with load-use interlock, branch flush and an optional FP multiply interlock.
// Optional feature macro: DLX_FP_MULT_INTERLOCK_EN (multiply occupancy stall).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   if_valid/instr  - fetched instruction and its valid flag
//   id_ready        - decode accepts if_instr this cycle
//   ex_taken        - EX resolved a taken branch/jump: flush the decode slot
//   ex/mem/wb_ctrl  - control bundles per stage (wb is zero if CTRL_DEPTH=2)
//   stall_cnt       - saturating count of cycles with id_ready low
module dlx_ctrl_pipe
  import dlx_ctrl_pkg::*;
#(
  parameter int MULT_LAT   = 4,
  parameter int CTRL_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [0:31]       if_instr,
  output logic              id_ready,
  input  logic              ex_taken,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [15:0]       stall_cnt
);

  if ((MULT_LAT < 2) || (MULT_LAT > 15)) begin : g_bad_mult_lat
    $error("dlx_ctrl_pipe: MULT_LAT must be 2..15");
  end
  if ((CTRL_DEPTH < 2) || (CTRL_DEPTH > 3)) begin : g_bad_depth
    $error("dlx_ctrl_pipe: CTRL_DEPTH must be 2..3");
  end

  ctrl_t       dec_s;
  ctrl_t       ex_r;
  ctrl_t       mem_r;
  ctrl_t       wb_r;
  logic        lu_hazard_s;
  logic        mult_hazard_s;
  logic        stall_s;
  logic        issue_s;
  logic [15:0] stall_cnt_r;

  dlx_ctrl_dec u_dec (
    .instr (if_instr),
    .ctrl  (dec_s)
  );

  // Load-use: a load in EX whose destination feeds the decoding instruction.
  // rs2 is only a real source for register-format ops and stores.
  always_comb begin
    lu_hazard_s = 1'b0;
    if (if_valid && ex_r.valid && ex_r.mem2reg && (ex_r.rd != 5'd0)) begin
      lu_hazard_s = (ex_r.rd == dec_s.rs1) ||
                    ((dec_s.reg_dst || dec_s.mem_wr) && (ex_r.rd == dec_s.rs2));
    end else begin
      lu_hazard_s = 1'b0;
    end
  end

`ifdef DLX_FP_MULT_INTERLOCK_EN
  logic [3:0] mult_cnt_r;
  logic       is_mult_s;

  assign is_mult_s     = (if_instr[0:5] == OP_FPR);
  assign mult_hazard_s = if_valid && (mult_cnt_r != 4'd0) &&
                         (is_mult_s || dec_s.fp_rd);

  // Multiply occupancy: load on issue of a multiply, then count down to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mult_cnt_r <= 4'd0;
    end else if (issue_s && is_mult_s) begin
      mult_cnt_r <= 4'(MULT_LAT - 1);
    end else if (mult_cnt_r != 4'd0) begin
      mult_cnt_r <= mult_cnt_r - 4'd1;
    end else begin
      mult_cnt_r <= mult_cnt_r;
    end
  end
`else
  assign mult_hazard_s = 1'b0;
`endif

  // A taken branch drops the decode slot, so it overrides every stall.
  assign stall_s  = (lu_hazard_s || mult_hazard_s) && !ex_taken;
  assign id_ready = !stall_s;
  assign issue_s  = if_valid && !stall_s && !ex_taken;

  // Control pipeline: anything not issued enters EX as an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else begin
      ex_r  <= issue_s ? dec_s : ctrl_t'('0);
      mem_r <= ex_r;
      wb_r  <= (CTRL_DEPTH == 3) ? mem_r : ctrl_t'('0);
    end
  end

  // Stall cycle counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign ex_ctrl   = ex_r;
  assign mem_ctrl  = mem_r;
  assign wb_ctrl   = wb_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_dlx_ctrl_pipe.sv
// tb_dlx_ctrl_pipe: self-checking bench for dlx_ctrl_pipe. Directed scenarios
// plus randomized traffic checked against a cycle-level reference model.
// Honours DLX_FP_MULT_INTERLOCK_EN in the same way as the design.
module tb_dlx_ctrl_pipe;

  localparam int MULT_LAT = 4;
  localparam int DEPTH    = 3;
`ifdef DLX_FP_MULT_INTERLOCK_EN
  localparam int MULT_STALLS = MULT_LAT - 1;
`else
  localparam int MULT_STALLS = 0;
`endif

  localparam logic [31:0] ADD_I  = 32'h0022_1820;  // add r3,r1,r2
  localparam logic [31:0] LW_I   = 32'h8C25_0000;  // lw r5,0(r1)
  localparam logic [31:0] DEP_I  = 32'h00A2_3020;  // add r6,r5,r2
  localparam logic [31:0] BEQZ_I = 32'h1020_0008;  // beqz r1
  localparam logic [31:0] MUL_I  = 32'h0422_1805;  // 000001 op, r3 <- r1,r2
  localparam logic [30:0] ADD_EXP = {12'b111001000000, 4'b0101, 5'd3, 5'd1, 5'd2};

  logic        clk = 1'b0;
  logic        rst, if_valid, ex_taken, id_ready;
  logic [31:0] if_instr;
  logic [30:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [30:0] m_ex = '0, m_mem = '0, m_wb = '0;
  logic        m_ex_load = 1'b0;
  logic [4:0]  m_ex_rd = 5'd0;
  int          m_stall = 0;
  int          cyc = 0;
  int          last_mult = -1000;
  logic        exp_ready, seen_ready;

  always #5 clk = ~clk;

  dlx_ctrl_pipe #(.MULT_LAT(MULT_LAT), .CTRL_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .id_ready  (id_ready),
    .ex_taken  (ex_taken),
    .ex_ctrl   (ex_ctrl),
    .mem_ctrl  (mem_ctrl),
    .wb_ctrl   (wb_ctrl),
    .stall_cnt (stall_cnt)
  );

  function automatic logic [3:0] alu_of_func(input int fn);
    case (fn)
      32, 33:  return 4'b0101;
      34, 35:  return 4'b1101;
      36:      return 4'b0000;
      37:      return 4'b0001;
      38:      return 4'b0010;
      40:      return 4'b1000;
      41:      return 4'b1001;
      42:      return 4'b1110;
      43:      return 4'b1100;
      44:      return 4'b1011;
      45:      return 4'b1010;
      4:       return 4'b0100;
      6:       return 4'b0111;
      7:       return 4'b0110;
      default: return 4'b0101;
    endcase
  endfunction

  // Expected bundle for an issued instruction; ins[31:26] is the opcode.
  function automatic logic [30:0] ref_decode(input logic [31:0] ins);
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    logic rdst  = (op <= 1);
    logic load  = (op >= 32 && op <= 39);
    logic store = (op >= 40 && op <= 47);
    logic br    = (op >= 4 && op <= 7);
    logic beq   = br && (op % 2 == 0);
    logic bne   = br && (op % 2 == 1);
    logic jmp   = (op == 18 || op == 19);
    logic wr    = !(store || br || jmp || ins == 32'h0000_0013);
    logic ext   = !(op == 9 || op == 11 || ins == 32'h0400_0016);
    logic [3:0] alu;
    logic [4:0] rd = rdst ? ins[15:11] : ins[20:16];
    if (op == 0)                             alu = alu_of_func(fn);
    else if (op == 1)                        alu = 4'b0011;
    else if (op >= 8 && op <= 14)            alu = alu_of_func(op + 24);
    else if (op == 20 || op == 22 || op == 23) alu = alu_of_func(op - 16);
    else if (op >= 24 && op <= 29)           alu = alu_of_func(op + 16);
    else                                     alu = 4'b0101;
    return {1'b1, rdst, wr, fn == 53, fn == 52, ext, op >= 8, store, load,
            beq, bne, jmp, alu, rd, ins[25:21], ins[20:16]};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op, fn;
    case ($urandom_range(0, 11))
      0, 1:    op = 6'h00;
      2:       op = 6'h01;
      3, 4:    op = 6'h23;
      5:       op = 6'h2b;
      6:       op = 6'h04;
      7:       op = 6'h05;
      8:       op = 6'h12;
      9:       op = 6'($urandom_range(8, 29));
      default: op = 6'($urandom_range(0, 63));
    endcase
    case ($urandom_range(0, 7))
      0:       fn = 6'h20;
      1:       fn = 6'h22;
      2:       fn = 6'h34;
      3:       fn = 6'h35;
      4:       fn = 6'h2a;
      5:       fn = 6'h04;
      default: fn = 6'($urandom_range(0, 63));
    endcase
    case ($urandom_range(0, 15))
      0:       return 32'h0000_0013;
      1:       return 32'h0400_0016;
      default: return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), fn};
    endcase
  endfunction

  // Drive one cycle, sample id_ready mid-cycle, advance the model on the edge.
  task automatic tick(input logic r, input logic v, input logic [31:0] ins,
                      input logic tk);
    int op = int'(ins[31:26]);
    logic [30:0] d = ref_decode(ins);
    logic ld_hz, ml_hz, iss;
    rst = r; if_valid = v; if_instr = ins; ex_taken = tk;
    ld_hz = v && m_ex_load && (m_ex_rd != 5'd0) &&
            ((m_ex_rd == ins[25:21]) ||
             ((op <= 1 || (op >= 40 && op <= 47)) && (m_ex_rd == ins[20:16])));
`ifdef DLX_FP_MULT_INTERLOCK_EN
    ml_hz = v && (cyc - last_mult < MULT_LAT) && (op == 1 || ins[5:0] == 6'h34);
`else
    ml_hz = 1'b0;
`endif
    exp_ready = !((ld_hz || ml_hz) && !tk);
    iss = v && exp_ready && !tk;
    @(negedge clk);
    seen_ready = id_ready;
    @(posedge clk);
    if (r) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_ex_load = 1'b0; m_ex_rd = 5'd0;
      m_stall = 0; last_mult = -1000;
    end else begin
      m_wb  = (DEPTH == 3) ? m_mem : '0;
      m_mem = m_ex;
      m_ex  = iss ? d : '0;
      m_ex_load = iss && (op >= 32 && op <= 39);
      m_ex_rd   = iss ? (op <= 1 ? ins[15:11] : ins[20:16]) : 5'd0;
      if (!exp_ready && m_stall < 65535) m_stall++;
      if (iss && op == 1) last_mult = cyc;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    total++; if (ex_ctrl !== 31'd0) begin bad++; $display("FAIL rst_ex got=%h want=0", ex_ctrl); end
    total++; if (mem_ctrl !== 31'd0) begin bad++; $display("FAIL rst_mem got=%h want=0", mem_ctrl); end
    total++; if (wb_ctrl !== 31'd0) begin bad++; $display("FAIL rst_wb got=%h want=0", wb_ctrl); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0d want=0", stall_cnt); end
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", id_ready); end
  endtask

  task automatic test_add();
    tick(1'b0, 1'b1, ADD_I, 1'b0);
    total++; if (ex_ctrl !== ADD_EXP) begin bad++; $display("FAIL add_ex got=%h want=%h", ex_ctrl, ADD_EXP); end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    total++; if (wb_ctrl !== ADD_EXP) begin bad++; $display("FAIL add_wb got=%h want=%h", wb_ctrl, ADD_EXP); end
  endtask

  task automatic test_load_use();
    tick(1'b0, 1'b1, LW_I, 1'b0);
    tick(1'b0, 1'b1, DEP_I, 1'b0);
    total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL lu_ready got=%b want=0", seen_ready); end
    total++; if (ex_ctrl !== 31'd0) begin bad++; $display("FAIL lu_bubble got=%h want=0", ex_ctrl); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cnt); end
    tick(1'b0, 1'b1, DEP_I, 1'b0);
    total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL lu_ready2 got=%b want=1", seen_ready); end
    total++; if (ex_ctrl[30] !== 1'b1 || ex_ctrl[14:10] !== 5'd6) begin
      bad++; $display("FAIL lu_issue got=%h want valid rd=6", ex_ctrl);
    end
  endtask

  task automatic test_flush();
    tick(1'b0, 1'b1, BEQZ_I, 1'b0);
    total++; if (ex_ctrl[21] !== 1'b1 || ex_ctrl[28] !== 1'b0) begin
      bad++; $display("FAIL fl_branch got=%h want branch=1 reg_wr=0", ex_ctrl);
    end
    tick(1'b0, 1'b1, ADD_I, 1'b1);
    total++; if (ex_ctrl[30] !== 1'b0) begin bad++; $display("FAIL fl_bubble got=%h want valid=0", ex_ctrl); end
    total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL fl_ready got=%b want=1", seen_ready); end
    tick(1'b0, 1'b1, ADD_I, 1'b0);
    total++; if (ex_ctrl !== ADD_EXP) begin bad++; $display("FAIL fl_next got=%h want=%h", ex_ctrl, ADD_EXP); end
    tick(1'b0, 1'b1, LW_I, 1'b0);
    tick(1'b0, 1'b1, DEP_I, 1'b1);
    total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL fl_over_lu got=%b want=1", seen_ready); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL fl_cnt got=%0d want=1", stall_cnt); end
  endtask

  task automatic test_nop();
    tick(1'b0, 1'b1, 32'h0000_0013, 1'b0);
    total++; if (ex_ctrl[30] !== 1'b1 || ex_ctrl[28] !== 1'b0) begin
      bad++; $display("FAIL nop got=%h want valid=1 reg_wr=0", ex_ctrl);
    end
  endtask

  task automatic test_back_to_back_mult();
    int stalls = 0;
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, MUL_I, 1'b0);
    total++; if (ex_ctrl[30:15] !== {12'b111001000000, 4'b0011}) begin
      bad++; $display("FAIL mul_ex got=%h want ctl=e403", ex_ctrl);
    end
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b1, MUL_I, 1'b0);
      if (seen_ready === 1'b1) break;
      stalls++;
    end
    total++; if (stalls != MULT_STALLS) begin bad++; $display("FAIL mul_stalls got=%0d want=%0d", stalls, MULT_STALLS); end
    total++; if (stall_cnt !== 16'(m_stall)) begin bad++; $display("FAIL mul_cnt got=%0d want=%0d", stall_cnt, m_stall); end
  endtask

  task automatic test_reset_mid_stall();
    tick(1'b0, 1'b1, LW_I, 1'b0);
    tick(1'b1, 1'b1, DEP_I, 1'b0);
    total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL rms_ready0 got=%b want=0", seen_ready); end
    total++; if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 93'd0) begin bad++; $display("FAIL rms_bundles got=%h want=0", ex_ctrl); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rms_cnt got=%0d want=0", stall_cnt); end
    tick(1'b0, 1'b1, DEP_I, 1'b0);
    total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL rms_ready1 got=%b want=1", seen_ready); end
    total++; if (ex_ctrl !== ref_decode(DEP_I)) begin bad++; $display("FAIL rms_issue got=%h want=%h", ex_ctrl, ref_decode(DEP_I)); end
  endtask

  task automatic test_random();
    logic r, v, tk;
    logic [31:0] ins;
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 63) == 0);
      v   = ($urandom_range(0, 4) != 0);
      tk  = ($urandom_range(0, 9) == 0);
      ins = rand_instr();
      tick(r, v, ins, tk);
      total++; if (seen_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, seen_ready, exp_ready); end
      total++; if (ex_ctrl !== m_ex) begin bad++; $display("FAIL rnd_ex n=%0d got=%h want=%h", n, ex_ctrl, m_ex); end
      total++; if (mem_ctrl !== m_mem) begin bad++; $display("FAIL rnd_mem n=%0d got=%h want=%h", n, mem_ctrl, m_mem); end
      total++; if (wb_ctrl !== m_wb) begin bad++; $display("FAIL rnd_wb n=%0d got=%h want=%h", n, wb_ctrl, m_wb); end
      total++; if (stall_cnt !== 16'(m_stall)) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d want=%0d", n, stall_cnt, m_stall); end
    end
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; ex_taken = 1'b0;
    test_reset();
    test_add();
    test_load_use();
    test_flush();
    test_nop();
    test_back_to_back_mult();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
